// File: rtl/uart_pkg.sv
// Shared types and default timing constants for the UART receive-side controller.
package uart_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMING   = 2'd1,
    ACTIVE   = 2'd2
  } rx_ctrl_state_t;

  localparam int OVERSAMPLE         = 16;
  localparam int FRAME_BITS         = 10;
  localparam int IDLE_TICKS_DFLT    = OVERSAMPLE * FRAME_BITS;
  localparam int TIMEOUT_TICKS_DFLT = 4 * IDLE_TICKS_DFLT;

  // Bits needed to hold a counter that can reach max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock DEPTH x WIDTH FIFO; a push while full is accepted only alongside a pop.
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: oversample tick, idle-line arming, byte capture FIFO, overrun and timeout.
// state    | meaning
// DISABLED | controller off, receiver held disabled
// ARMING   | waiting for IDLE_TICKS consecutive high-line ticks
// ACTIVE   | receiver enabled, bytes captured into FIFO
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int DIV_W         = 16,
  parameter int IDLE_TICKS    = IDLE_TICKS_DFLT,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DFLT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_en,
  input  logic [DIV_W-1:0]           cfg_div,
  input  logic                       i_rx,
  input  logic [7:0]                 rx_data_in,
  input  logic                       rx_valid_in,
  output logic                       rx_en_o,
  output logic                       rx_tick_o,
  output logic [7:0]                 m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic                       timeout
);

  localparam int IDLE_W = cnt_width(IDLE_TICKS);
  localparam int TO_W   = cnt_width(TIMEOUT_TICKS);

  rx_ctrl_state_t    state, state_nxt;
  logic [1:0]        rx_sync;
  logic              rx_s;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick_q, tick;
  logic [IDLE_W-1:0] idle_cnt;
  logic              arm_done;
  logic              valid_q, push, pop;
  logic              fifo_full, fifo_empty;
  logic [TO_W-1:0]   to_cnt;
  logic              to_clr, to_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], i_rx};
  end
  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else if (!cfg_en) begin
      div_cnt <= cfg_div;
      tick_q  <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt <= cfg_div;
      tick_q  <= 1'b1;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
      tick_q  <= 1'b0;
    end
  end
  // Gate so a tick registered just before disable never escapes.
  assign tick      = tick_q & cfg_en;
  assign rx_tick_o = tick;

  assign arm_done = tick & rx_s & (idle_cnt == IDLE_W'(IDLE_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           idle_cnt <= '0;
    else if (state != ARMING || !rx_s)    idle_cnt <= '0;
    else if (tick)                        idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DISABLED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_en_o   = 1'b0;
    case (state)
      DISABLED: if (cfg_en) state_nxt = ARMING;
      ARMING:   if (arm_done) state_nxt = ACTIVE;
      ACTIVE:   rx_en_o = 1'b1;
      default:  state_nxt = DISABLED;
    endcase
    if (!cfg_en) state_nxt = DISABLED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= rx_valid_in;
  end

  assign push    = rx_valid_in & ~valid_q & (state == ACTIVE) & cfg_en;
  assign pop     = m_valid & m_ready;
  assign m_valid = ~fifo_empty;

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (rx_data_in),
    .rdata (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         overrun <= 1'b0;
    else if (push & fifo_full & ~pop)   overrun <= 1'b1;
    else if (overrun_clr)               overrun <= 1'b0;
  end

  // Counter saturates at TIMEOUT_TICKS so the pulse fires once per clear.
  assign to_clr = push | pop | ~rx_s | (state != ACTIVE);
  assign to_inc = tick & ~fifo_empty & (to_cnt != TO_W'(TIMEOUT_TICKS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (to_clr) begin
        to_cnt <= '0;
      end else if (to_inc) begin
        to_cnt  <= to_cnt + TO_W'(1);
        timeout <= (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
      end
    end
  end

endmodule
